verify_ingress_sequencer: RTL and testbench
===========================================

// Module: verify_ingress_sequencer
// PURPOSE
// Core-side responder for the verify-mode host stream. It accepts the fixed word sequence
// RHO, C, Z, T1, MLEN, MSG, H on the valid_i/ready_i interface and tags each word with a
// field ID and word index. Tagged words go to the verify datapath through a one-stage output
// register. The block then returns a single accept/reject word to the host on valid_o/ready_o.
// PARAMETERS
// W          64  data word width in bits (multiple of 8)
// SEED_WORDS  4  words in RHO and in C
// Z_WORDS   160  words in Z
// T1_WORDS  160  words in T1
// H_WORDS    12  words in H
// MLEN_W     64  width of msg length in bytes, taken from data_i[MLEN_W-1:0]
// PORTS
// clk       in   1      clock
// rst_n     in   1      asynchronous reset, active low
// start     in   1      one-cycle pulse that begins a verify transaction
// valid_i   in   1      host word valid
// ready_i   out  1      block can accept data_i
// data_i    in   W      host word
// fld_valid out  1      tagged word valid to datapath
// fld_ready in   1      datapath accepts tagged word
// fld_data  out  W      tagged word
// fld_id    out  3      0=RHO 1=C 2=Z 3=T1 4=MLEN 5=MSG 6=H
// fld_idx   out  16     word index within field, 0-based
// fld_last  out  1      last word of the field
// res_valid in   1      datapath verdict strobe
// res_rej   in   1      verdict (1=reject); sampled with res_valid
// valid_o   out  1      result word valid to host
// ready_o   in   1      host accepts result
// data_o    out  W      {W-1 zeros, reject}
// busy      out  1      state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; ready_i, fld_valid, valid_o, busy = 0;
//   fld_data, fld_id, fld_idx, fld_last, data_o = 0; counters and stored mlen = 0.
// - States: IDLE -> RHO -> C -> Z -> T1 -> MLEN -> MSG -> H -> WAIT_RES -> SEND_RES -> IDLE.
// - IDLE: start=1 -> RHO, idx=0. start in any other state is ignored.
// - Input states: ready_i = !fld_valid | fld_ready, so accept and drain can share a cycle.
//   - Accept means valid_i & ready_i.
//   - On accept: fld_* loaded on the next edge and idx incremented.
//   - Last word of a field: fld_last=1, idx cleared, advance to next state.
// - Latency data_i -> fld_data is one cycle. Full throughput while fld_ready is held high.
// - fld_* hold stable while fld_valid & !fld_ready.
// - Field word counts:
//   - RHO and C: SEED_WORDS each.
//   - Z: Z_WORDS. T1: T1_WORDS. H: H_WORDS.
//   - MLEN: 1 word. mlen = data_i[MLEN_W-1:0] is stored.
//   - MSG: max(1, ceil(mlen*8/W)) words. mlen=0 still consumes one word (fld_last=1).
//   - MSG count arithmetic is done at MLEN_W+1 bits, so there is no overflow.
// - Non-input states (IDLE, WAIT_RES, SEND_RES): ready_i = 0. Words offered there are not consumed.
// - WAIT_RES: the first cycle with res_valid=1 latches reject=res_rej and moves to SEND_RES.
//   - fld_valid must have drained; res_valid is ignored while fld_valid=1.
//   - res_valid in any other state is ignored.
// - SEND_RES: valid_o=1, data_o = {0, reject}, both held until ready_o.
//   - valid_o & ready_o -> IDLE. valid_o drops on the next edge.
//   - A start pulse in that same cycle is ignored.
// - rst_n low mid-transaction: immediate return to reset values. Partial data is discarded.
// TESTING
// (Benches use W=64, SEED_WORDS=4, Z_WORDS=5, T1_WORDS=3, H_WORDS=2.)
// - Happy path: start, 21 words with valid_i held, mlen=16, fld_ready=1, res_rej=0.
//   -> fld_id/idx sequence 0:0-3, 1:0-3, 2:0-4, 3:0-2, 4:0, 5:0-1, 6:0-1.
//   -> 21 fld beats, fld_last on idx 3/3/4/2/0/1/1.
//   -> then valid_o=1 with data_o=0.
// - Backpressure: fld_ready toggles 1,0,0,1 every 4 cycles.
//   -> fld_* stable while stalled, no word lost or duplicated, ready_i=0 only when full and stalled.
// - Msg lengths: mlen=0 -> 1 MSG word; mlen=8 -> 1; mlen=9 -> 2; mlen=17 -> 3.
//   -> MSG fld_last on the final word in each case.
// - Reject plus host stall: res_rej=1, then ready_o held 0 for 10000 cycles.
//   -> valid_o stays 1 with data_o=1 throughout.
//   -> ready_o=1 -> IDLE and busy=0 on the next cycle.
// - Upstream gap: 10000-cycle valid_i=0 pause after MLEN, as the host idles.
//   -> state stays MSG, no spurious fld_valid.
// - Reset mid-Z (rst_n pulsed low):
//   -> all outputs 0 asynchronously, then a fresh start works with idx restarted at 0.
//   -> stray start or res_valid outside IDLE/WAIT_RES has no effect.

Source files
------------

// File: rtl/verify_ingress_sequencer.sv
// Verify-mode ingress sequencer: tags the fixed host word stream with field id/index, forwards it
// through a one-stage output register, then returns the datapath's accept/reject word to the host.
module verify_ingress_sequencer #(
    parameter int unsigned W          = 64,
    parameter int unsigned SEED_WORDS = 4,
    parameter int unsigned Z_WORDS    = 160,
    parameter int unsigned T1_WORDS   = 160,
    parameter int unsigned H_WORDS    = 12,
    parameter int unsigned MLEN_W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         valid_i,
    output logic         ready_i,
    input  logic [W-1:0] data_i,
    output logic         fld_valid,
    input  logic         fld_ready,
    output logic [W-1:0] fld_data,
    output logic [2:0]   fld_id,
    output logic [15:0]  fld_idx,
    output logic         fld_last,
    input  logic         res_valid,
    input  logic         res_rej,
    output logic         valid_o,
    input  logic         ready_o,
    output logic [W-1:0] data_o,
    output logic         busy
);

    localparam int unsigned CW  = MLEN_W + 1;
    localparam int unsigned BPW = W / 8;

    typedef enum logic [3:0] {
        StIdle, StRho, StC, StZ, StT1, StMlen, StMsg, StH, StWaitRes, StSendRes
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [MLEN_W-1:0]   mlen_q;
    logic                rej_q;
    logic                fld_valid_q;
    logic [W-1:0]        fld_data_q;
    logic [2:0]          fld_id_q;
    logic [15:0]         fld_idx_q;
    logic                fld_last_q;

    logic                in_field;
    logic                acc;
    logic                is_last;
    logic [2:0]          cur_id;
    logic [CW-1:0]       last_idx;
    logic [CW-1:0]       msg_words;
    logic                res_take;

    // Byte count rounded up to whole words; an empty message still occupies one word.
    assign msg_words = ({1'b0, mlen_q} + CW'(BPW - 1)) / CW'(BPW);

    always_comb begin
        in_field = 1'b1;
        cur_id   = 3'd0;
        last_idx = '0;
        case (state_q)
            StRho:   begin cur_id = 3'd0; last_idx = CW'(SEED_WORDS - 1); end
            StC:     begin cur_id = 3'd1; last_idx = CW'(SEED_WORDS - 1); end
            StZ:     begin cur_id = 3'd2; last_idx = CW'(Z_WORDS - 1);    end
            StT1:    begin cur_id = 3'd3; last_idx = CW'(T1_WORDS - 1);   end
            StMlen:  begin cur_id = 3'd4; last_idx = '0;                  end
            StMsg:   begin
                cur_id   = 3'd5;
                last_idx = (msg_words == '0) ? '0 : msg_words - CW'(1);
            end
            StH:     begin cur_id = 3'd6; last_idx = CW'(H_WORDS - 1);    end
            default: in_field = 1'b0;
        endcase
    end

    assign ready_i  = in_field & (~fld_valid_q | fld_ready);
    assign acc      = valid_i & ready_i;
    assign is_last  = (cnt_q == last_idx);
    assign res_take = (state_q == StWaitRes) & res_valid & ~fld_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start)             state_d = StRho;
            StRho:     if (acc && is_last)    state_d = StC;
            StC:       if (acc && is_last)    state_d = StZ;
            StZ:       if (acc && is_last)    state_d = StT1;
            StT1:      if (acc && is_last)    state_d = StMlen;
            StMlen:    if (acc && is_last)    state_d = StMsg;
            StMsg:     if (acc && is_last)    state_d = StH;
            StH:       if (acc && is_last)    state_d = StWaitRes;
            StWaitRes: if (res_take)          state_d = StSendRes;
            StSendRes: if (ready_o)           state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mlen_q      <= '0;
            rej_q       <= 1'b0;
            fld_valid_q <= 1'b0;
            fld_data_q  <= '0;
            fld_id_q    <= 3'd0;
            fld_idx_q   <= 16'd0;
            fld_last_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                cnt_q <= '0;
            end else if (acc) begin
                cnt_q <= is_last ? '0 : cnt_q + CW'(1);
            end
            if (acc && state_q == StMlen) begin
                mlen_q <= data_i[MLEN_W-1:0];
            end
            if (res_take) begin
                rej_q <= res_rej;
            end
            if (acc) begin
                fld_valid_q <= 1'b1;
                fld_data_q  <= data_i;
                fld_id_q    <= cur_id;
                fld_idx_q   <= cnt_q[15:0];
                fld_last_q  <= is_last;
            end else if (fld_ready) begin
                fld_valid_q <= 1'b0;
            end
        end
    end

    assign fld_valid = fld_valid_q;
    assign fld_data  = fld_data_q;
    assign fld_id    = fld_id_q;
    assign fld_idx   = fld_idx_q;
    assign fld_last  = fld_last_q;
    assign valid_o   = (state_q == StSendRes);
    assign data_o    = {{(W - 1){1'b0}}, valid_o & rej_q};
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_verify_ingress_sequencer.sv
// Randomized directed bench for verify_ingress_sequencer: a queue of expected tagged beats is built
// from the field-length rules as words are offered and checked against every datapath beat.
module tb_verify_ingress_sequencer;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i;
    logic [W-1:0]  data_i = '0;
    logic          fld_valid;
    logic          fld_ready = 1'b1;
    logic [W-1:0]  fld_data;
    logic [2:0]    fld_id;
    logic [15:0]   fld_idx;
    logic          fld_last;
    logic          res_valid = 1'b0;
    logic          res_rej = 1'b0;
    logic          valid_o;
    logic          ready_o = 1'b0;
    logic [W-1:0]  data_o;
    logic          busy;

    verify_ingress_sequencer #(
        .W(64), .SEED_WORDS(4), .Z_WORDS(5), .T1_WORDS(3), .H_WORDS(2), .MLEN_W(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .valid_i(valid_i), .ready_i(ready_i), .data_i(data_i),
        .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_data(fld_data),
        .fld_id(fld_id), .fld_idx(fld_idx), .fld_last(fld_last),
        .res_valid(res_valid), .res_rej(res_rej),
        .valid_o(valid_o), .ready_o(ready_o), .data_o(data_o), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        int          idx;
        logic        last;
        logic [63:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    int    n_beats = 0;
    int    cyc = 0;
    bit    bp_mode = 1'b0;
    bit    in_input = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Datapath backpressure: 1,0,0,1 pattern, each phase 4 cycles long.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (bp_mode) fld_ready = (((cyc / 4) % 4) == 0) || (((cyc / 4) % 4) == 3);
        else         fld_ready = 1'b1;
    end

    logic        prev_stall = 1'b0;
    logic [63:0] p_data;
    logic [2:0]  p_id;
    logic [15:0] p_idx;
    logic        p_last;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tags", 64'({fld_valid, fld_id, fld_idx, fld_last}),
                      64'({1'b1, p_id, p_idx, p_last}));
                check("stall_data", fld_data, p_data);
            end
            if (in_input && !ready_i) check("ready_i_low_cause", 64'(fld_valid && !fld_ready), 64'd1);
            if (fld_valid && fld_ready) begin
                n_beats++;
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_mis++;
                    $error("FAIL extra_beat observed=id%0d/idx%0d expected=no beat", fld_id, fld_idx);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("fld_id", 64'(fld_id), 64'(e.id));
                    check("fld_idx", 64'(fld_idx), 64'(e.idx));
                    check("fld_last", 64'(fld_last), 64'(e.last));
                    check("fld_data", fld_data, e.data);
                end
            end
            prev_stall = fld_valid && !fld_ready;
            p_data = fld_data; p_id = fld_id; p_idx = fld_idx; p_last = fld_last;
        end
    end

    task automatic check_reset_outputs();
        check("rst_ready_i", 64'(ready_i), 64'd0);
        check("rst_fld_valid", 64'(fld_valid), 64'd0);
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fld_tags", 64'({fld_id, fld_idx, fld_last}), 64'd0);
        check("rst_fld_data", fld_data, 64'd0);
        check("rst_data_o", data_o, 64'd0);
    endtask

    task automatic send_word(input logic [63:0] d);
        int t = 0;
        bit done = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        while (!done && t < 300) begin
            @(negedge clk);
            if (ready_i) done = 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        valid_i = 1'b0;
        n_cmp++;
        assert (done === 1'b1) else begin
            n_mis++;
            $error("FAIL send_timeout observed=not accepted expected=accepted");
        end
    endtask

    task automatic send_field(input int f, input int len, input logic [63:0] mlen);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.id   = 3'(f);
            b.idx  = i;
            b.last = (i == len - 1);
            b.data = (f == 4) ? mlen : {$urandom, $urandom};
            exp_q.push_back(b);
            send_word(b.data);
        end
    endtask

    task automatic start_txn(input bit bp);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        bp_mode = bp;
        in_input = 1'b1;
    endtask

    task automatic run_txn(input logic [63:0] mlen, input bit rej, input bit bp,
                           input int stall, input int gap);
        int lens[7];
        int mw;
        int total;
        int b0;
        int t;
        int bad;
        mw    = (mlen == 0) ? 1 : int'((mlen * 8 + 63) / 64);
        lens  = '{4, 4, 5, 3, 1, mw, 2};
        total = 0;
        foreach (lens[k]) total += lens[k];
        b0 = n_beats;
        start_txn(bp);
        for (int f = 0; f < 7; f++) begin
            // Stray control strobes while busy must not disturb the stream.
            if (f == 0) start = 1'b1;
            if (f == 2) res_valid = 1'b1;
            send_field(f, lens[f], mlen);
            start = 1'b0;
            res_valid = 1'b0;
            if (f == 4 && gap > 0) begin
                bad = 0;
                for (int k = 0; k < gap; k++) begin
                    @(negedge clk);
                    if ((k > 20 && fld_valid) || !busy) bad++;
                end
                check("gap_no_spurious", 64'(bad), 64'd0);
                check("gap_ready_i", 64'(ready_i), 64'd1);
                @(posedge clk);
                #1;
            end
        end
        in_input = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((fld_valid || exp_q.size() != 0) && t < 200);
        check("drain_fld_valid", 64'(fld_valid), 64'd0);
        check("beat_count", 64'(n_beats - b0), 64'(total));
        valid_i = 1'b1;
        data_i  = {$urandom, $urandom};
        repeat (3) begin
            @(negedge clk);
            check("wait_ready_i", 64'(ready_i), 64'd0);
            check("wait_no_fld", 64'(fld_valid), 64'd0);
        end
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        res_rej   = rej;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        res_rej   = ~rej;
        @(negedge clk);
        check("res_valid_o", 64'(valid_o), 64'd1);
        check("res_data_o", data_o, 64'(rej));
        check("res_busy", 64'(busy), 64'd1);
        if (stall > 0) begin
            bad = 0;
            repeat (stall) begin
                @(negedge clk);
                if (valid_o !== 1'b1 || data_o !== 64'(rej)) bad++;
            end
            check("res_held", 64'(bad), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_o = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        ready_o = 1'b0;
        start   = 1'b0;
        bp_mode = 1'b0;
        @(negedge clk);
        check("done_valid_o", 64'(valid_o), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("idle_after_start", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        valid_i = 1'b1;
        @(negedge clk);
        check("idle_ready_i", 64'(ready_i), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;

        run_txn(64'd16, 1'b0, 1'b0, 0, 0);
        run_txn(64'd17, 1'b0, 1'b1, 0, 0);
        run_txn(64'd0, 1'b1, 1'b0, 0, 0);
        run_txn(64'd8, 1'b0, 1'b1, 0, 0);
        run_txn(64'd9, 1'b1, 1'b0, 0, 0);
        run_txn(64'd5, 1'b1, 1'b0, 10000, 0);
        run_txn(64'd24, 1'b0, 1'b0, 0, 10000);
        for (int r = 0; r < 3; r++) begin
            run_txn(64'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), 0, 0);
        end

        // Abort in the middle of Z, then a fresh transaction must restart from RHO idx 0.
        start_txn(1'b0);
        send_field(0, 4, 64'd0);
        send_field(1, 4, 64'd0);
        send_field(2, 2, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        in_input = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(64'd16, 1'b1, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
